// File: rtl/fan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fan_ctrl_pkg
// Description : Shared types and frame-layout constants for the fan
//               controller coefficient loader.
// Revision    : 1.0 - initial release
// ============================================================================
package fan_ctrl_pkg;

    localparam int COEF_W           = 32;
    localparam int C_NUM_WORDS      = 5;
    localparam int C_BYTES_PER_WORD = 4;
    localparam int C_NUM_BYTES      = C_NUM_WORDS * C_BYTES_PER_WORD;
    localparam int C_CNT_W          = 5;

    // Frame byte offsets of each coefficient; each word is sent little-endian.
    localparam int C_BYTE_B2 = 0;
    localparam int C_BYTE_B1 = 4;
    localparam int C_BYTE_B0 = 8;
    localparam int C_BYTE_A1 = 12;
    localparam int C_BYTE_A0 = 16;

    localparam int C_WORD_B2 = C_BYTE_B2 / C_BYTES_PER_WORD;
    localparam int C_WORD_B1 = C_BYTE_B1 / C_BYTES_PER_WORD;
    localparam int C_WORD_B0 = C_BYTE_B0 / C_BYTES_PER_WORD;
    localparam int C_WORD_A1 = C_BYTE_A1 / C_BYTES_PER_WORD;
    localparam int C_WORD_A0 = C_BYTE_A0 / C_BYTES_PER_WORD;

    localparam logic [C_CNT_W-1:0] C_LAST_BYTE = C_CNT_W'(C_NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_CHECK   = 2'd2,
        ST_PENDING = 2'd3
    } state_t;

    function automatic logic [C_CNT_W-1:0] byte_index(input int word, input int lane);
        return C_CNT_W'(word * C_BYTES_PER_WORD + lane);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fan_coef_if.sv
`default_nettype none
// ============================================================================
// Module      : fan_coef_if
// Description : Switch/strobe input pins and coefficient/status outputs of
//               the coefficient loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface fan_coef_if #(
    parameter int COEF_W = fan_ctrl_pkg::COEF_W
);
    logic [7:0]        data_i;
    logic              strb_i;
    logic              cfg_i;
    logic              clk_en_pid_i;
    logic [COEF_W-1:0] b2_o;
    logic [COEF_W-1:0] b1_o;
    logic [COEF_W-1:0] b0_o;
    logic [COEF_W-1:0] a1_o;
    logic [COEF_W-1:0] a0_o;
    logic              busy_o;
    logic              err_o;
    logic              upd_o;

    modport master (
        output data_i, strb_i, cfg_i, clk_en_pid_i,
        input  b2_o, b1_o, b0_o, a1_o, a0_o, busy_o, err_o, upd_o
    );

    modport slave (
        input  data_i, strb_i, cfg_i, clk_en_pid_i,
        output b2_o, b1_o, b0_o, a1_o, a0_o, busy_o, err_o, upd_o
    );
endinterface
`default_nettype wire

// File: rtl/fan_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : fan_sync_edge
// Description : Two-flop synchroniser for a strobe pin plus companion bits,
//               with rising-edge detect on the strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module fan_sync_edge #(
    parameter int W = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         strb_i,
    input  wire logic [W-1:0] d_i,
    output logic              rise_o,
    output logic [W-1:0]      q_o
);

    logic [W:0] meta_q, meta_d;
    logic [W:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic [1:0] vld_q,  vld_d;

    // prev is held high until the chain carries real pin samples, so a pin
    // already high at reset release never looks like a rising edge.
    always_comb begin
        meta_d = {d_i, strb_i};
        sync_d = meta_q;
        vld_d  = {vld_q[0], 1'b1};
        prev_d = sync_q[0] | ~vld_q[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= 1'b1;
            vld_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            vld_q  <= vld_d;
        end
    end

    assign rise_o = sync_q[0] & ~prev_q;
    assign q_o    = sync_q[W:1];

endmodule
`default_nettype wire

// File: rtl/fan_coef_loader.sv
`default_nettype none
// ============================================================================
// Module      : fan_coef_loader
// Description : Loads five PID coefficients from a strobed byte stream into a
//               shadow, verifies an XOR checksum and commits on a PID sample.
// Revision    : 1.0 - initial release
// ============================================================================
module fan_coef_loader #(
    parameter int                COEF_W = fan_ctrl_pkg::COEF_W,
    parameter logic [COEF_W-1:0] DEF_B2 = '0,
    parameter logic [COEF_W-1:0] DEF_B1 = '0,
    parameter logic [COEF_W-1:0] DEF_B0 = '0,
    parameter logic [COEF_W-1:0] DEF_A1 = '0,
    parameter logic [COEF_W-1:0] DEF_A0 = '0
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    fan_coef_if.slave  bus
);

    import fan_ctrl_pkg::*;

    typedef logic [C_NUM_WORDS-1:0][COEF_W-1:0] words_t;

    // Word 0 (LSB) is b2, matching the frame order.
    localparam words_t C_DEF_COEFS = {DEF_A0, DEF_A1, DEF_B0, DEF_B1, DEF_B2};

    logic       w_strb_evt;
    logic       w_cfg_s;
    logic [7:0] w_byte_s;

    fan_sync_edge #(
        .W (9)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .strb_i (bus.strb_i),
        .d_i    ({bus.cfg_i, bus.data_i}),
        .rise_o (w_strb_evt),
        .q_o    ({w_cfg_s, w_byte_s})
    );

    state_t             state_q,  state_d;
    logic [C_CNT_W-1:0] cnt_q,    cnt_d;
    logic [7:0]         xor_q,    xor_d;
    words_t             shadow_q, shadow_d;
    words_t             coef_q,   coef_d;
    logic               err_q,    err_d;
    logic               upd_q,    upd_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        xor_d    = xor_q;
        shadow_d = shadow_q;
        coef_d   = coef_q;
        err_d    = err_q;
        upd_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_strb_evt && w_cfg_s) begin
                    shadow_d       = '0;
                    shadow_d[0][7:0] = w_byte_s;
                    xor_d          = w_byte_s;
                    cnt_d          = C_CNT_W'(1);
                    err_d          = 1'b0;
                    state_d        = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (!w_cfg_s) begin
                    shadow_d = '0;
                    cnt_d    = '0;
                    xor_d    = '0;
                    state_d  = ST_IDLE;
                end else if (w_strb_evt) begin
                    for (int w = 0; w < C_NUM_WORDS; w++) begin
                        for (int b = 0; b < C_BYTES_PER_WORD; b++) begin
                            if (cnt_q == byte_index(w, b)) begin
                                shadow_d[w][8*b +: 8] = w_byte_s;
                            end
                        end
                    end
                    xor_d = xor_q ^ w_byte_s;
                    if (cnt_q == C_LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_CHECK: begin
                if (!w_cfg_s) begin
                    shadow_d = '0;
                    cnt_d    = '0;
                    xor_d    = '0;
                    state_d  = ST_IDLE;
                end else if (w_strb_evt) begin
                    xor_d = '0;
                    if (w_byte_s == xor_q) begin
                        state_d = ST_PENDING;
                    end else begin
                        err_d    = 1'b1;
                        shadow_d = '0;
                        state_d  = ST_IDLE;
                    end
                end
            end

            // Strobes and cfg are deliberately ignored while a commit waits.
            ST_PENDING: begin
                if (bus.clk_en_pid_i) begin
                    coef_d  = shadow_q;
                    upd_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            xor_q    <= '0;
            shadow_q <= '0;
            coef_q   <= C_DEF_COEFS;
            err_q    <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            xor_q    <= xor_d;
            shadow_q <= shadow_d;
            coef_q   <= coef_d;
            err_q    <= err_d;
            upd_q    <= upd_d;
        end
    end

    assign bus.b2_o   = coef_q[C_WORD_B2];
    assign bus.b1_o   = coef_q[C_WORD_B1];
    assign bus.b0_o   = coef_q[C_WORD_B0];
    assign bus.a1_o   = coef_q[C_WORD_A1];
    assign bus.a0_o   = coef_q[C_WORD_A0];
    assign bus.busy_o = (state_q != ST_IDLE);
    assign bus.err_o  = err_q;
    assign bus.upd_o  = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_fan_coef_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fan_coef_loader
// Description : Self-checking bench for fan_coef_loader; expected commits are
//               queued as frames are sent and compared on each upd_o pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fan_coef_loader;

    // Word k of a coefs_t: 0=b2, 1=b1, 2=b0, 3=a1, 4=a0.
    typedef logic [4:0][31:0] coefs_t;

    localparam logic [31:0] D_B2 = 32'hA5A5_0001;
    localparam logic [31:0] D_B1 = 32'h0000_0002;
    localparam logic [31:0] D_B0 = 32'h8000_0000;
    localparam logic [31:0] D_A1 = 32'h7FFF_FFFF;
    localparam logic [31:0] D_A0 = 32'hDEAD_BEEF;
    localparam coefs_t      DEFS = {D_A0, D_A1, D_B0, D_B1, D_B2};

    logic   clk = 1'b0;
    logic   rst_n;
    int     errors   = 0;
    int     checks   = 0;
    int     upd_cnt  = 0;
    int     upd_long = 0;
    logic   upd_prev = 1'b0;
    coefs_t exp_q[$];

    fan_coef_if #(.COEF_W(32)) bus ();

    fan_coef_loader #(
        .COEF_W (32),
        .DEF_B2 (D_B2),
        .DEF_B1 (D_B1),
        .DEF_B0 (D_B0),
        .DEF_A1 (D_A1),
        .DEF_A0 (D_A0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #50 clk = ~clk;

    always @(negedge clk) begin
        if (bus.upd_o === 1'b1) begin
            upd_cnt <= upd_cnt + 1;
            if (upd_prev) upd_long <= upd_long + 1;
        end
        upd_prev <= bus.upd_o;
    end

    function automatic coefs_t observe();
        coefs_t o;
        o[0] = bus.b2_o;
        o[1] = bus.b1_o;
        o[2] = bus.b0_o;
        o[3] = bus.a1_o;
        o[4] = bus.a0_o;
        return o;
    endfunction

    function automatic logic [7:0] frame_byte(input coefs_t c, input int k);
        return c[k/4][8*(k%4) +: 8];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.data_i = b;
        bus.strb_i = 1'b1;
        repeat (5) @(negedge clk);
        bus.strb_i = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input coefs_t c, input logic [7:0] csum_flip);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < 20; k++) begin
            send_byte(frame_byte(c, k));
            x = x ^ frame_byte(c, k);
        end
        send_byte(x ^ csum_flip);
    endtask

    task automatic pulse_en();
        @(negedge clk);
        bus.clk_en_pid_i = 1'b1;
        @(negedge clk);
        bus.clk_en_pid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (observe() !== DEFS) begin errors++; $display("FAIL reset_coefs got=%h exp=%h", observe(), DEFS); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
        checks++; if (bus.upd_o !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b exp=0", bus.upd_o); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_ones();
        coefs_t c, e;
        int     n;
        c = {5{32'h1111_1111}};
        bus.cfg_i = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(c, 8'h00);
        exp_q.push_back(c);
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL ones_pending_busy got=%b exp=1", bus.busy_o); end
        checks++; if (observe() !== DEFS) begin errors++; $display("FAIL ones_precommit got=%h exp=%h", observe(), DEFS); end
        pulse_en();
        n = 0;
        while (bus.upd_o !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        checks++; if (bus.upd_o !== 1'b1) begin errors++; $display("FAIL ones_upd got=%b exp=1", bus.upd_o); end
        e = exp_q.pop_front();
        checks++; if (observe() !== e) begin errors++; $display("FAIL ones_coefs got=%h exp=%h", observe(), e); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL ones_err got=%b exp=0", bus.err_o); end
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL ones_idle_busy got=%b exp=0", bus.busy_o); end
    endtask

    task automatic test_b2_one();
        coefs_t c, e, prev;
        int     n;
        prev = observe();
        c    = '0;
        c[0] = 32'h4000_0000;
        send_frame(c, 8'h00);
        exp_q.push_back(c);
        repeat (6) @(negedge clk);
        checks++; if (bus.b2_o !== 32'h1111_1111) begin errors++; $display("FAIL b2_before_commit got=%h exp=11111111", bus.b2_o); end
        checks++; if (observe() !== prev) begin errors++; $display("FAIL b2_no_partial got=%h exp=%h", observe(), prev); end
        pulse_en();
        n = 0;
        while (bus.upd_o !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        checks++; if (bus.upd_o !== 1'b1) begin errors++; $display("FAIL b2_upd got=%b exp=1", bus.upd_o); end
        e = exp_q.pop_front();
        checks++; if (observe() !== e) begin errors++; $display("FAIL b2_coefs got=%h exp=%h", observe(), e); end
    endtask

    task automatic test_bad_checksum();
        int n;
        do_reset();
        send_frame({5{32'h1111_1111}}, 8'h01);
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL badck_err got=%b exp=1", bus.err_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL badck_busy got=%b exp=0", bus.busy_o); end
        checks++; if (observe() !== DEFS) begin errors++; $display("FAIL badck_coefs got=%h exp=%h", observe(), DEFS); end
        repeat (2) @(negedge clk);
        n = upd_cnt;
        pulse_en();
        repeat (4) @(negedge clk);
        checks++; if (upd_cnt !== n) begin errors++; $display("FAIL badck_no_upd got=%0d exp=%0d", upd_cnt, n); end
    endtask

    task automatic test_abort();
        coefs_t c, e;
        int     n;
        c = {32'h7654_3210, 32'hFEDC_BA98, 32'h89AB_CDEF, 32'h0123_4567, 32'hC000_0000};
        send_byte(frame_byte(c, 0));
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL abort_err_clear got=%b exp=0", bus.err_o); end
        for (int k = 1; k < 8; k++) send_byte(frame_byte(c, k));
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL abort_loading got=%b exp=1", bus.busy_o); end
        bus.cfg_i = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy_o); end
        checks++; if (observe() !== DEFS) begin errors++; $display("FAIL abort_coefs got=%h exp=%h", observe(), DEFS); end
        bus.cfg_i = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(c, 8'h00);
        exp_q.push_back(c);
        pulse_en();
        n = 0;
        while (bus.upd_o !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        checks++; if (bus.upd_o !== 1'b1) begin errors++; $display("FAIL abort_upd got=%b exp=1", bus.upd_o); end
        e = exp_q.pop_front();
        checks++; if (observe() !== e) begin errors++; $display("FAIL abort_coefs_commit got=%h exp=%h", observe(), e); end
    endtask

    task automatic test_back_to_back();
        coefs_t c, e;
        c = {32'h0000_0005, 32'hFFFF_FFFB, 32'h1234_5678, 32'h8765_4321, 32'h2000_0000};
        send_frame(c, 8'h00);
        exp_q.push_back(c);
        send_byte(8'hFF);
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL b2b_stray_busy got=%b exp=1", bus.busy_o); end
        bus.cfg_i = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL b2b_cfg_low_pending got=%b exp=1", bus.busy_o); end
        bus.cfg_i = 1'b1;
        repeat (5) @(negedge clk);
        // The strobe edge reaches the FSM on the third rising edge after the
        // pin rises, the same edge that samples clk_en_pid_i below.
        bus.data_i = 8'h5A;
        bus.strb_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.clk_en_pid_i = 1'b1;
        @(negedge clk);
        bus.clk_en_pid_i = 1'b0;
        checks++; if (bus.upd_o !== 1'b1) begin errors++; $display("FAIL b2b_upd got=%b exp=1", bus.upd_o); end
        e = exp_q.pop_front();
        checks++; if (observe() !== e) begin errors++; $display("FAIL b2b_coefs got=%h exp=%h", observe(), e); end
        repeat (3) @(negedge clk);
        bus.strb_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_strobe_ignored got=%b exp=0", bus.busy_o); end
        bus.cfg_i = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h33);
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_cfg_low_strobe got=%b exp=0", bus.busy_o); end
        bus.cfg_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_pending();
        int n;
        send_frame({5{32'h0F0F_0F0F}}, 8'h00);
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL rstp_pending got=%b exp=1", bus.busy_o); end
        n = upd_cnt;
        #20;
        rst_n      = 1'b0;
        bus.strb_i = 1'b1;
        #1;
        checks++; if (observe() !== DEFS) begin errors++; $display("FAIL rstp_async_coefs got=%h exp=%h", observe(), DEFS); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rstp_async_busy got=%b exp=0", bus.busy_o); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rstp_no_capture got=%b exp=0", bus.busy_o); end
        pulse_en();
        repeat (4) @(negedge clk);
        checks++; if (upd_cnt !== n) begin errors++; $display("FAIL rstp_no_upd got=%0d exp=%0d", upd_cnt, n); end
        checks++; if (observe() !== DEFS) begin errors++; $display("FAIL rstp_coefs got=%h exp=%h", observe(), DEFS); end
        bus.strb_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_totals();
        checks++; if (upd_cnt !== 4) begin errors++; $display("FAIL total_upd got=%0d exp=4", upd_cnt); end
        checks++; if (upd_long !== 0) begin errors++; $display("FAIL upd_width got=%0d exp=0", upd_long); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.data_i       = 8'h00;
        bus.strb_i       = 1'b0;
        bus.cfg_i        = 1'b0;
        bus.clk_en_pid_i = 1'b0;
        test_reset();
        test_all_ones();
        test_b2_one();
        test_bad_checksum();
        test_abort();
        test_back_to_back();
        test_reset_pending();
        test_totals();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
